stage_buf: RTL and testbench
============================

# stage_buf

Parametrised pipeline stage buffer that carries the per-instruction bundle (PC, instruction word, instruction-set tag) between pipeline stages. It generalises the plain pass-through stage register: it stores up to DEPTH bundles in order and adds a valid/ready handshake, backpressure, occupancy reporting and a synchronous flush. It can be inserted between any two stages, including after the final register-operation stage.

## Interface
- PC_W, 12, width of the PC field
- INSTR_W, 12, width of the instruction field
- SET_W, 4, width of the instruction-set tag
- DEPTH, 2, number of buffered bundles; power of two, 1..8
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
- flush  input  1  synchronous discard of all buffered bundles
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  buffer can accept a bundle this cycle
- in_pc  input  PC_W  upstream PC
- in_instr  input  INSTR_W  upstream instruction
- in_set  input  SET_W  upstream instruction-set tag
- out_valid  output  1  head bundle valid
- out_ready  input  1  downstream accepts the head bundle
- out_pc  output  PC_W  head PC
- out_instr  output  INSTR_W  head instruction
- out_set  output  SET_W  head instruction-set tag
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries, with write pointer wp, read pointer rp and occupancy counter cnt. The pointers are $clog2(DEPTH) bits wide (1 bit when DEPTH=1) and wrap naturally from DEPTH-1 to 0.
- Output and ready signals:
  - in_ready = (cnt != DEPTH). It is a function of state only, with no combinational path from out_ready.
  - out_valid = (cnt != 0).
- Push: in_valid && in_ready.
  - Writes {in_pc, in_instr, in_set} to entry wp.
  - Increments wp.
- Pop: out_valid && out_ready.
  - Increments rp.
- Count update:
  - Push only: cnt+1.
  - Pop only: cnt-1.
  - Push and pop together: cnt unchanged. This is legal at any occupancy below DEPTH.
- Full: in_ready=0. in_valid is ignored and the data is neither written nor lost from storage. Upstream holds the bundle.
- Empty: out_valid=0. out_pc, out_instr and out_set are forced to 0. They never show stale entries.
- Non-empty: out_* = entry rp. Bundles leave in exactly the order they arrived.
- Flush (flush=1 at an edge):
  - Sets cnt=0 and wp=rp=0.
  - Any push or pop offered in the same cycle is discarded. Flush has priority.
  - Entry contents need not be cleared, but out_* read 0 because the buffer is empty.
- count = cnt.
- Reset (rst=0, asynchronous): cnt=0, wp=rp=0, all entries=0.
  - Outputs during and after reset: out_valid=0, in_ready=1, out_pc=out_instr=out_set=0, count=0.
  - Reset asserted mid-operation drops all buffered bundles immediately, without waiting for an edge.
- Deassertion of rst takes effect at the following edge. The first push is accepted at the first edge with rst=1.

## Timing
- Latency: a bundle pushed at edge N is on out_* with out_valid=1 after edge N (in cycle N+1). There is no combinational in_*→out_* path.
- Throughput:
  - DEPTH≥2: one bundle per cycle sustained.
  - DEPTH=1: one bundle per two cycles, because in_ready drops while the single entry is occupied.
- in_ready and out_valid change only after clock edges or on asynchronous reset.
- Upstream may change in_* freely while in_valid=0. No protocol requirement is placed on upstream beyond sampling at edges.
- Downstream sees out_* stable while out_valid=1 and out_ready=0.
- Flush in cycle N: after edge N, out_valid=0, count=0 and in_ready=1.

## Test plan
- Reset values: hold rst=0 with random inputs.
  - Required: out_valid=0, in_ready=1, count=0, out_pc/out_instr/out_set=0.
  - Release rst, push {pc=0x123, instr=0xABC, set=0x5}: out_* = 0x123/0xABC/0x5 with out_valid=1 one cycle later.
- Streaming (DEPTH=2): out_ready=1 constantly, push PC 0..15 on consecutive cycles.
  - Required: in_ready stays 1, outputs PC 0..15 on consecutive cycles with 1-cycle latency, count ≤1.
- Backpressure and wrap (DEPTH=4): out_ready=0, push PC 1..6.
  - Required: PC 1..4 accepted, count=4, in_ready=0, PC 5 held upstream.
  - Then set out_ready=1 and keep pushing: output order 1,2,3,4,5,6 with pointers wrapping, no loss or duplication.
- Simultaneous push and pop at occupancy DEPTH-1 (DEPTH=4, count=3).
  - Required: count stays 3, and the popped PC and the appended PC are correct.
- Flush priority: count=3, then in one cycle assert flush=1, in_valid=1 (PC 0x7F), out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_*=0.
  - PC 0x7F never appears on the output.
- Reset mid-operation: count=2, drop rst to 0 between edges.
  - Required: out_valid=0, count=0, out_*=0 immediately, without waiting for an edge.
  - After release, a new push appears alone, with no old data.

Source files
------------

// File: rtl/stage_buf.sv
// stage_buf: in-order circular buffer of DEPTH {pc, instr, set} bundles
// with valid/ready on both sides, occupancy count and synchronous flush.
// Ports: clk, rst (async active-low), flush; in_valid/in_ready/in_pc/
// in_instr/in_set upstream; out_valid/out_ready/out_pc/out_instr/out_set
// downstream; count = occupancy 0..DEPTH.
module stage_buf #(
   parameter int PC_W    = 12,
   parameter int INSTR_W = 12,
   parameter int SET_W   = 4,
   parameter int DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INSTR_W-1:0]       in_instr,
   input  logic [SET_W-1:0]         in_set,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [SET_W-1:0]         out_set,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = PC_W + INSTR_W + SET_W;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;
   logic [EW-1:0] head;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      // explicit wrap keeps DEPTH=1 (1-bit pointer) pinned at 0
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (cnt_q != CW'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // empty buffer never exposes a stale entry
   assign head = out_valid ? mem_q[rp_q] : '0;
   assign out_pc    = head[EW-1 -: PC_W];
   assign out_instr = head[SET_W +: INSTR_W];
   assign out_set   = head[SET_W-1:0];
   assign count     = cnt_q;

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wp_q] = {in_pc, in_instr, in_set};
            wp_d        = inc(wp_q);
         end
         if (pop) begin
            rp_d = inc(rp_q);
         end
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_stage_buf.sv
// tb_stage_buf: directed table plus hand sequences for stage_buf,
// one DEPTH=2 and one DEPTH=4 instance sharing the same stimulus.
module tb_stage_buf;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [11:0] in_pc;
   logic [11:0] in_instr;
   logic [3:0]  in_set;
   logic        out_ready;

   logic        ir2, ov2, ir4, ov4;
   logic [11:0] pc2, ins2, pc4, ins4;
   logic [3:0]  set2, set4;
   logic [1:0]  cnt2;
   logic [2:0]  cnt4;

   int checks = 0;
   int errors = 0;

   stage_buf #(.PC_W(12), .INSTR_W(12), .SET_W(4), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir2),
      .in_pc(in_pc), .in_instr(in_instr), .in_set(in_set),
      .out_valid(ov2), .out_ready(out_ready),
      .out_pc(pc2), .out_instr(ins2), .out_set(set2),
      .count(cnt2)
   );

   stage_buf #(.PC_W(12), .INSTR_W(12), .SET_W(4), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir4),
      .in_pc(in_pc), .in_instr(in_instr), .in_set(in_set),
      .out_valid(ov4), .out_ready(out_ready),
      .out_pc(pc4), .out_instr(ins4), .out_set(set4),
      .count(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [11:0] pc;
      logic        orr;
      logic        ir;
      logic        ov;
      logic [11:0] opc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vt [18];

   function automatic vec_t v(input int fl, iv, pc, orr,
                              input int ir, ov, opc, cnt);
      vec_t r;
      r.fl  = fl[0];
      r.iv  = iv[0];
      r.pc  = pc[11:0];
      r.orr = orr[0];
      r.ir  = ir[0];
      r.ov  = ov[0];
      r.opc = opc[11:0];
      r.cnt = cnt[2:0];
      return r;
   endfunction

   function automatic logic [11:0] f_instr(input logic [11:0] p);
      return ~p;
   endfunction

   function automatic logic [3:0] f_set(input logic [11:0] p);
      return p[3:0] ^ 4'hA;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [11:0] p,
                        input logic orr);
      in_valid  = iv;
      in_pc     = p;
      in_instr  = f_instr(p);
      in_set    = f_set(p);
      out_ready = orr;
   endtask

   task automatic chk4(input string tag, input logic ir,
                       input logic ov, input logic [11:0] opc,
                       input logic [2:0] cnt);
      chk({tag, ".in_ready"}, 32'(ir4), 32'(ir));
      chk({tag, ".out_valid"}, 32'(ov4), 32'(ov));
      chk({tag, ".out_pc"}, 32'(pc4), 32'(ov ? opc : 12'h0));
      chk({tag, ".out_instr"}, 32'(ins4),
          32'(ov ? f_instr(opc) : 12'h0));
      chk({tag, ".out_set"}, 32'(set4), 32'(ov ? f_set(opc) : 4'h0));
      chk({tag, ".count"}, 32'(cnt4), 32'(cnt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset held with random inputs
      rst       = 1'b0;
      flush     = 1'($urandom);
      in_valid  = 1'($urandom);
      in_pc     = 12'($urandom);
      in_instr  = 12'($urandom);
      in_set    = 4'($urandom);
      out_ready = 1'($urandom);
      step();
      step();
      chk4("rst4", 1'b1, 1'b0, 12'h0, 3'd0);
      chk("rst2.in_ready", 32'(ir2), 32'd1);
      chk("rst2.out_valid", 32'(ov2), 32'd0);
      chk("rst2.out_pc", 32'(pc2), 32'd0);
      chk("rst2.count", 32'(cnt2), 32'd0);

      // first push right after release
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 12'h123;
      in_instr  = 12'hABC;
      in_set    = 4'h5;
      out_ready = 1'b0;
      step();
      chk("first.out_valid", 32'(ov4), 32'd1);
      chk("first.out_pc", 32'(pc4), 32'h123);
      chk("first.out_instr", 32'(ins4), 32'hABC);
      chk("first.out_set", 32'(set4), 32'h5);
      chk("first.count", 32'(cnt4), 32'd1);
      drive(1'b0, 12'h0, 1'b1);
      step();
      chk("first_pop.count", 32'(cnt4), 32'd0);

      // DEPTH=4 table: backpressure, wrap, push+pop at 3, flush
      //       fl iv pc     or  ir ov opc    cnt
      vt[0]  = v(0, 1, 'h001, 0, 1, 1, 'h001, 1);
      vt[1]  = v(0, 1, 'h002, 0, 1, 1, 'h001, 2);
      vt[2]  = v(0, 1, 'h003, 0, 1, 1, 'h001, 3);
      vt[3]  = v(0, 1, 'h004, 0, 0, 1, 'h001, 4);
      vt[4]  = v(0, 1, 'h005, 0, 0, 1, 'h001, 4);
      vt[5]  = v(0, 1, 'h005, 1, 1, 1, 'h002, 3);
      vt[6]  = v(0, 1, 'h005, 1, 1, 1, 'h003, 3);
      vt[7]  = v(0, 1, 'h006, 1, 1, 1, 'h004, 3);
      vt[8]  = v(0, 0, 'h000, 1, 1, 1, 'h005, 2);
      vt[9]  = v(0, 0, 'h000, 1, 1, 1, 'h006, 1);
      vt[10] = v(0, 0, 'h000, 1, 1, 0, 'h000, 0);
      vt[11] = v(0, 1, 'h010, 0, 1, 1, 'h010, 1);
      vt[12] = v(0, 1, 'h011, 0, 1, 1, 'h010, 2);
      vt[13] = v(0, 1, 'h012, 0, 1, 1, 'h010, 3);
      vt[14] = v(1, 1, 'h07F, 1, 1, 0, 'h000, 0);
      vt[15] = v(0, 0, 'h000, 1, 1, 0, 'h000, 0);
      vt[16] = v(0, 1, 'h020, 0, 1, 1, 'h020, 1);
      vt[17] = v(0, 0, 'h000, 1, 1, 0, 'h000, 0);
      for (int i = 0; i < 18; i++) begin
         flush = vt[i].fl;
         drive(vt[i].iv, vt[i].pc, vt[i].orr);
         step();
         chk4($sformatf("vec%0d", i), vt[i].ir, vt[i].ov,
              vt[i].opc, vt[i].cnt);
      end
      flush = 1'b0;

      // DEPTH=2 streaming, start from empty
      flush = 1'b1;
      drive(1'b0, 12'h0, 1'b0);
      step();
      flush = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("strm%0d.in_ready", i), 32'(ir2), 32'd1);
         drive(1'b1, 12'(i), 1'b1);
         step();
         chk($sformatf("strm%0d.out_valid", i), 32'(ov2), 32'd1);
         chk($sformatf("strm%0d.out_pc", i), 32'(pc2), 32'(i));
         chk($sformatf("strm%0d.count", i), 32'(cnt2), 32'd1);
      end
      drive(1'b0, 12'h0, 1'b1);
      step();
      chk("strm_end.count", 32'(cnt2), 32'd0);

      // mid-operation reset between edges
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b1, 12'h030, 1'b0);
      step();
      drive(1'b1, 12'h031, 1'b0);
      step();
      chk("pre_rst.count", 32'(cnt4), 32'd2);
      drive(1'b0, 12'h0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk4("async_rst", 1'b1, 1'b0, 12'h0, 3'd0);
      chk("async_rst2.count", 32'(cnt2), 32'd0);
      step();
      rst = 1'b1;
      drive(1'b1, 12'h040, 1'b0);
      step();
      chk4("post_rst", 1'b1, 1'b1, 12'h040, 3'd1);
      drive(1'b0, 12'h0, 1'b1);
      step();
      chk4("post_rst_pop", 1'b1, 1'b0, 12'h0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
